// File: rtl/rgb_pwm_engine.sv
// rgb_pwm_engine: multi-channel PWM generator with run-time duty writes
// and an optional per-channel linear fade toward a target duty.
module rgb_pwm_engine #(
   parameter int CHANNELS     = 3,
   parameter int WIDTH        = 8,
   parameter int PRESCALE     = 1024,
   parameter int FADE_PERIODS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [2:0]          wr_ch,
   input  logic [WIDTH-1:0]    wr_duty,
   input  logic                wr_fade,
   output logic [CHANNELS-1:0] pwm,
   output logic                period_start,
   output logic                busy
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int FW = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
   localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
   localparam logic [FW-1:0] FADE_MAX = FW'(FADE_PERIODS - 1);

   logic [PW-1:0]       pre;
   logic [WIDTH-1:0]    cnt;
   logic [FW-1:0]       fcnt;
   logic                tick;
   logic                wrap;
   logic                step;
   logic                hs;
   logic                apply;

   logic                pend_v;
   logic [2:0]          pend_ch;
   logic [WIDTH-1:0]    pend_duty;
   logic                pend_fade;

   logic [WIDTH-1:0]    cur   [CHANNELS];
   logic [WIDTH-1:0]    tgt   [CHANNELS];
   logic [CHANNELS-1:0] fade;
   logic [WIDTH-1:0]    cur_n [CHANNELS];
   logic [WIDTH-1:0]    tgt_n [CHANNELS];
   logic [CHANNELS-1:0] fade_n;
   logic [CHANNELS-1:0] pwm_n;
   logic                busy_n;

   assign tick     = (pre == PRE_MAX);
   assign wrap     = tick && (cnt == '1);
   assign step     = wrap && (fcnt == FADE_MAX);
   assign wr_ready = !pend_v;
   assign hs       = wr_valid && wr_ready;
   assign apply    = wrap && pend_v;

   // A channel being written on this wrap takes the new values and skips its step.
   always_comb begin
      busy_n = 1'b0;
      fade_n = fade;
      pwm_n  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         logic hit;
         logic mv;
         cur_n[i] = cur[i];
         tgt_n[i] = tgt[i];
         hit      = apply && (pend_ch == 3'(i));
         mv       = !hit && step && fade[i] && (cur[i] != tgt[i]);
         unique case (1'b1)
            hit: begin
               tgt_n[i]  = pend_duty;
               fade_n[i] = pend_fade;
               if (!pend_fade)
                  cur_n[i] = pend_duty;
            end
            mv: begin
               if (cur[i] < tgt[i])
                  cur_n[i] = cur[i] + 1'b1;
               else
                  cur_n[i] = cur[i] - 1'b1;
            end
            default: ;
         endcase
         busy_n   = busy_n | (cur_n[i] != tgt_n[i]);
         pwm_n[i] = (cnt < cur[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre          <= '0;
         cnt          <= '0;
         fcnt         <= '0;
         pend_v       <= 1'b0;
         pend_ch      <= '0;
         pend_duty    <= '0;
         pend_fade    <= 1'b0;
         fade         <= '0;
         pwm          <= '0;
         period_start <= 1'b0;
         busy         <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            cur[i] <= '0;
            tgt[i] <= '0;
         end
      end else begin
         pre <= tick ? '0 : pre + 1'b1;
         if (tick)
            cnt <= cnt + 1'b1;
         if (wrap) begin
            fcnt   <= step ? '0 : fcnt + 1'b1;
            pend_v <= 1'b0;
         end
         // A write taken on the wrap clock itself waits for the next wrap.
         if (hs) begin
            pend_v    <= 1'b1;
            pend_ch   <= wr_ch;
            pend_duty <= wr_duty;
            pend_fade <= wr_fade;
         end
         fade         <= fade_n;
         pwm          <= pwm_n;
         period_start <= wrap;
         busy         <= busy_n;
         for (int i = 0; i < CHANNELS; i++) begin
            cur[i] <= cur_n[i];
            tgt[i] <= tgt_n[i];
         end
      end
   end

endmodule
